irq4_responder: RTL and testbench

Four-source interrupt responder for a KCPSM3 system. It accepts four asynchronous active-low request lines, synchronises and masks them, and picks one by fixed priority. It drives the single INTERRUPT input of the processor, completes the INTERRUPT/INTERRUPT_ACK handshake, and returns a one-cycle acknowledge to the selected source. It also exposes the serviced vector to software through an input port and holds it until software signals completion.

---
 rtl/irq4_pkg.sv | 25 ++
 rtl/irq_sync.sv | 23 ++
 rtl/irq4_responder.sv | 91 +++++++++
 tb/tb_irq4_responder.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq4_pkg.sv
// Shared constants, FSM encoding and fixed-priority select for the four-source interrupt responder.
package irq4_pkg;

    localparam int unsigned NUM_SRC = 4;
    localparam int unsigned ID_W    = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Returns {one_hot, id} of the lowest-index set bit; bit 0 wins.
    function automatic logic [NUM_SRC+ID_W-1:0] prio_sel(input logic [NUM_SRC-1:0] pending);
        logic [NUM_SRC+ID_W-1:0] sel;
        sel = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel = {NUM_SRC'(1 << i), ID_W'(i)};
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Single-bit synchroniser chain; resets to 1 so an idle active-low line reads as released.
module irq_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/irq4_responder.sv
// Four-source interrupt responder: synchronise, mask, fixed-priority select and
// KCPSM3 INTERRUPT/INTERRUPT_ACK handshake with a per-source acknowledge pulse.
module irq4_responder
    import irq4_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_irq_n,
    input  logic [NUM_SRC-1:0] i_mask,
    output logic               o_interrupt,
    input  logic               i_interrupt_ack,
    input  logic               i_done,
    output logic [NUM_SRC-1:0] o_vector,
    output logic [ID_W-1:0]    o_vec_id,
    output logic [NUM_SRC-1:0] o_src_ack,
    output logic [NUM_SRC-1:0] o_pending
);

    logic [NUM_SRC-1:0] w_sync_n;
    logic [NUM_SRC-1:0] w_pending;

    state_t             r_state;
    logic               r_interrupt;
    logic [NUM_SRC-1:0] r_vector;
    logic [ID_W-1:0]    r_vec_id;
    logic [NUM_SRC-1:0] r_src_ack;

    for (genvar g = 0; g < int'(NUM_SRC); g++) begin : g_sync
        irq_sync #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_d     (i_irq_n[g]),
            .o_q     (w_sync_n[g])
        );
    end

    assign w_pending = ~w_sync_n & i_mask;

    // A latched selection is never withdrawn; late or spurious requests are settled by software.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_interrupt <= 1'b0;
            r_vector    <= '0;
            r_vec_id    <= '0;
            r_src_ack   <= '0;
        end else begin
            r_src_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (|w_pending) begin
                        {r_vector, r_vec_id} <= prio_sel(w_pending);
                        r_interrupt          <= 1'b1;
                        r_state              <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_interrupt_ack) begin
                        r_interrupt <= 1'b0;
                        r_src_ack   <= r_vector;
                        r_state     <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (i_done) begin
                        r_vector <= '0;
                        r_vec_id <= '0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_interrupt <= 1'b0;
                    r_vector    <= '0;
                    r_vec_id    <= '0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_interrupt = r_interrupt;
    assign o_vector    = r_vector;
    assign o_vec_id    = r_vec_id;
    assign o_src_ack   = r_src_ack;
    assign o_pending   = w_pending;

endmodule

// File: tb/tb_irq4_responder.sv
// Directed bench for irq4_responder: expectations queued at drive time, popped when outputs are sampled.
module tb_irq4_responder;

    localparam int unsigned SYNC = 2;

    logic       clk;
    logic       rst_n;
    logic [3:0] irq_n;
    logic [3:0] mask;
    logic       interrupt;
    logic       interrupt_ack;
    logic       done;
    logic [3:0] vector;
    logic [1:0] vec_id;
    logic [3:0] src_ack;
    logic [3:0] pending;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    irq4_responder #(
        .SYNC_STAGES (SYNC)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_irq_n         (irq_n),
        .i_mask          (mask),
        .o_interrupt     (interrupt),
        .i_interrupt_ack (interrupt_ack),
        .i_done          (done),
        .o_vector        (vector),
        .o_vec_id        (vec_id),
        .o_src_ack       (src_ack),
        .o_pending       (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [7:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL sb_empty: observed %0h expected none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_mis++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic strobe_ack();
        interrupt_ack = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
    endtask

    task automatic strobe_done();
        done = 1'b1;
        tick(1);
        done = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n         = 1'b0;
        irq_n         = 4'hF;
        mask          = 4'hF;
        interrupt_ack = 1'b0;
        done          = 1'b0;

        // Reset state
        expect_val("rst_int", 8'd0);
        expect_val("rst_vec", 8'd0);
        expect_val("rst_id", 8'd0);
        expect_val("rst_ack", 8'd0);
        expect_val("rst_pend", 8'd0);
        tick(3);
        check(8'(interrupt));
        check(8'(vector));
        check(8'(vec_id));
        check(8'(src_ack));
        check(8'(pending));
        rst_n = 1'b1;
        tick(2);

        // Single source 1: latency, ignored DONE in REQ, ACK pulse, ignored ACK in SERVICE
        irq_n = 4'b1101;
        expect_val("s1_int_early", 8'd0);
        tick(SYNC);
        check(8'(interrupt));
        expect_val("s1_int", 8'd1);
        expect_val("s1_vec", 8'b0010);
        expect_val("s1_id", 8'd1);
        expect_val("s1_pend", 8'b0010);
        tick(1);
        check(8'(interrupt));
        check(8'(vector));
        check(8'(vec_id));
        check(8'(pending));
        expect_val("s1_done_in_req_int", 8'd1);
        expect_val("s1_done_in_req_ack", 8'd0);
        strobe_done();
        check(8'(interrupt));
        check(8'(src_ack));
        expect_val("s1_ack_int", 8'd0);
        expect_val("s1_ack_pulse", 8'b0010);
        strobe_ack();
        check(8'(interrupt));
        check(8'(src_ack));
        expect_val("s1_ack_end", 8'd0);
        expect_val("s1_vec_hold", 8'b0010);
        tick(1);
        check(8'(src_ack));
        check(8'(vector));
        irq_n = 4'hF;
        expect_val("s1_ack_in_svc", 8'd0);
        expect_val("s1_vec_svc", 8'b0010);
        strobe_ack();
        check(8'(src_ack));
        check(8'(vector));
        expect_val("s1_done_vec", 8'd0);
        expect_val("s1_done_id", 8'd0);
        strobe_done();
        check(8'(vector));
        check(8'(vec_id));
        expect_val("s1_idle_int", 8'd0);
        tick(2);
        check(8'(interrupt));
        expect_val("idle_done_int", 8'd0);
        expect_val("idle_done_vec", 8'd0);
        strobe_done();
        check(8'(interrupt));
        check(8'(vector));

        // Priority: sources 1 and 3, then re-arbitration one cycle after DONE
        irq_n = 4'b0101;
        expect_val("pr_id_first", 8'd1);
        tick(SYNC + 1);
        check(8'(vec_id));
        expect_val("pr_ack1", 8'b0010);
        strobe_ack();
        check(8'(src_ack));
        irq_n = 4'b0111;
        tick(SYNC);
        expect_val("pr_done_int", 8'd0);
        expect_val("pr_done_vec", 8'd0);
        strobe_done();
        check(8'(interrupt));
        check(8'(vector));
        expect_val("pr_int2", 8'd1);
        expect_val("pr_id2", 8'd3);
        expect_val("pr_vec2", 8'b1000);
        tick(1);
        check(8'(interrupt));
        check(8'(vec_id));
        check(8'(vector));
        // Coincident ACK and DONE in REQ: go to SERVICE only
        expect_val("co_int", 8'd0);
        expect_val("co_ack", 8'b1000);
        expect_val("co_vec", 8'b1000);
        expect_val("co_id", 8'd3);
        interrupt_ack = 1'b1;
        done          = 1'b1;
        tick(1);
        interrupt_ack = 1'b0;
        done          = 1'b0;
        check(8'(interrupt));
        check(8'(src_ack));
        check(8'(vector));
        check(8'(vec_id));
        irq_n = 4'hF;
        tick(SYNC);
        expect_val("co_done_vec", 8'd0);
        strobe_done();
        check(8'(vector));
        expect_val("co_idle_int", 8'd0);
        tick(1);
        check(8'(interrupt));

        // Masking
        mask  = 4'b1110;
        irq_n = 4'b1110;
        expect_val("mk_int", 8'd0);
        expect_val("mk_pend", 8'd0);
        tick(SYNC + 2);
        check(8'(interrupt));
        check(8'(pending));
        mask = 4'hF;
        #1;
        expect_val("mk_pend_open", 8'b0001);
        check(8'(pending));
        expect_val("mk_int_open", 8'd1);
        expect_val("mk_id", 8'd0);
        expect_val("mk_vec", 8'b0001);
        tick(1);
        check(8'(interrupt));
        check(8'(vec_id));
        check(8'(vector));

        // Source withdrawal while in REQ
        irq_n = 4'hF;
        expect_val("wd_int_held", 8'd1);
        expect_val("wd_pend", 8'd0);
        tick(SYNC + 1);
        check(8'(interrupt));
        check(8'(pending));
        expect_val("wd_ack_int", 8'd0);
        expect_val("wd_ack_pulse", 8'b0001);
        strobe_ack();
        check(8'(interrupt));
        check(8'(src_ack));
        expect_val("wd_done_vec", 8'd0);
        strobe_done();
        check(8'(vector));
        tick(1);

        // Reset mid-operation
        irq_n = 4'b1011;
        expect_val("rs_int", 8'd1);
        expect_val("rs_id", 8'd2);
        tick(SYNC + 1);
        check(8'(interrupt));
        check(8'(vec_id));
        rst_n = 1'b0;
        #1;
        expect_val("rs_abort_int", 8'd0);
        expect_val("rs_abort_vec", 8'd0);
        expect_val("rs_abort_id", 8'd0);
        expect_val("rs_abort_ack", 8'd0);
        check(8'(interrupt));
        check(8'(vector));
        check(8'(vec_id));
        check(8'(src_ack));
        rst_n = 1'b1;
        expect_val("rs_rel_early", 8'd0);
        tick(SYNC);
        check(8'(interrupt));
        expect_val("rs_rel_int", 8'd1);
        expect_val("rs_rel_vec", 8'b0100);
        tick(1);
        check(8'(interrupt));
        check(8'(vector));
        expect_val("rs_ack", 8'b0100);
        strobe_ack();
        check(8'(src_ack));

        if (sb.size() != 0) begin
            n_cmp++;
            n_mis++;
            $error("FAIL sb_leftover: observed %0d expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
